param_mem_fifo: RTL
===================

PARAM_MEM_FIFO -- requirements
Module: param_mem_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 3, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 chip_select  input  1  block enable; when 0, no read, write or pointer activity.
REQ-006 mode  input  1  0 = RAM (addressed), 1 = FIFO (pointer-addressed).
REQ-007 write_en  input  1  write request.
REQ-008 read_en  input  1  read request.
REQ-009 address  input  ADDR_WIDTH  word address; used in RAM mode only, ignored in FIFO mode.
REQ-010 data_in  input  DATA_WIDTH  write data.
REQ-011 data_out  output  DATA_WIDTH  registered read data.
REQ-012 data_valid  output  1  one-cycle pulse: data_out was updated this cycle.
REQ-013 full  output  1  FIFO mode: count == DEPTH; forced 0 in RAM mode.
REQ-014 empty  output  1  FIFO mode: count == 0; forced 1 in RAM mode.
REQ-015 count  output  ADDR_WIDTH+1  FIFO occupancy, 0..DEPTH; forced 0 in RAM mode.
REQ-016 overflow  output  1  sticky: a FIFO write was rejected because the FIFO was full.
REQ-017 underflow  output  1  sticky: a FIFO read was rejected because the FIFO was empty.

Function
REQ-018 Read latency SHALL be 1 cycle: data_out and data_valid update on the edge that samples the accepted read.
REQ-019 data_out SHALL hold its last value when no read is accepted.
REQ-020 RAM mode, cs=1, write_en=1: mem[address] <= data_in.
REQ-021 RAM mode, cs=1, read_en=1: data_out <= mem[address].
REQ-022 RAM mode, simultaneous read and write to the same address: both are performed; data_out returns the old contents (read-before-write).
REQ-023 FIFO mode: a write is accepted iff cs=1, write_en=1 and (not full, or a read is accepted in the same cycle); accepted write stores at wr_ptr, then wr_ptr increments.
REQ-024 FIFO mode: a read is accepted iff cs=1, read_en=1 and not empty; accepted read loads mem[rd_ptr] into data_out, then rd_ptr increments.
REQ-025 FIFO mode, full, read and write in the same cycle: both are accepted; count is unchanged; overflow is not set.
REQ-026 FIFO mode, empty, read and write in the same cycle: the write is accepted, the read is rejected, underflow is set, and count becomes 1.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0; count SHALL be updated as +1, -1 or 0 per cycle and never leave the range 0..DEPTH.
REQ-028 A rejected write (full) SHALL set overflow; a rejected read (empty) SHALL set underflow; both flags are cleared only by reset.
REQ-029 A change of mode, detected against the previously registered mode, SHALL clear wr_ptr, rd_ptr and count in that cycle without altering memory contents; requests in that cycle SHALL be ignored.
REQ-030 cs=0 SHALL suppress all requests; data_valid = 0; flags and pointers hold.

Reset
REQ-031 reset=1 at a rising edge: all memory words, data_out, data_valid, overflow, underflow, pointers and count SHALL be set to 0, and the registered mode SHALL be loaded from the mode input.
REQ-032 Reset SHALL take priority over every request in the same cycle, including mid-stream FIFO operation.

Structure
REQ-033 A shared package param_mem_pkg SHALL hold MODE_RAM=1'b0, MODE_FIFO=1'b1 and the default DATA_WIDTH and ADDR_WIDTH.
REQ-034 The storage array SHALL be a sub-module mem_core (synchronous write, synchronous read, synchronous clear); pointer, count and flag logic SHALL live in the top level.

Verification
REQ-035 RAM mode: write AA,B3,1E,82,C4,F3,68,44 to addresses 0..7, then read 0..7 -> data_out equals the same sequence, each value 1 cycle after its read, with data_valid pulsed.
REQ-036 RAM mode: write 5D to address 3 while reading address 3 (previously 82) -> data_out=82; the next read of address 3 -> 5D.
REQ-037 FIFO mode: 8 writes 01..08 -> full=1, count=8; a 9th write of 09 -> overflow=1, count=8; 8 reads -> 01..08 in order, then empty=1.
REQ-038 FIFO mode: full, simultaneous write of 10 and read -> data_out=01, count stays 8; after draining, the last value read is 10.
REQ-039 FIFO mode: read while empty -> underflow=1, data_valid=0; assert reset mid-stream with count=5 -> count=0, data_out=00, flags cleared.
REQ-040 FIFO mode with 3 entries, switch to RAM mode -> count=0; a RAM read of address 0 returns the first FIFO word written.

Source files
------------

// File: rtl/param_mem_pkg.sv
// Shared definitions for the dual-mode (RAM / FIFO) parameter memory.
//   MODE_RAM / MODE_FIFO : encodings of the mode input
//   DEFAULT_DATA_WIDTH   : default word width in bits
//   DEFAULT_ADDR_WIDTH   : default address width (depth = 2**ADDR_WIDTH)
package param_mem_pkg;
  localparam logic MODE_RAM  = 1'b0;
  localparam logic MODE_FIFO = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;
endpackage

// File: rtl/mem_core.sv
// Storage array for param_mem_fifo: synchronous write, synchronous registered
// read, synchronous clear of every word and of the read register.
// Ports:
//   clock    : rising-edge clock
//   clear    : synchronous clear (all words and rd_data to 0)
//   wr_en    : write wr_data into mem[wr_addr]
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : load rd_data from mem[rd_addr]; rd_data holds otherwise
//   rd_addr  : read address
//   rd_data  : registered read data
module mem_core
  import param_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read and write share one edge; the read samples the old word, so a
  // same-address read/write returns the previous contents.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end
endmodule

// File: rtl/param_mem_fifo.sv
// Dual-mode word memory: addressed RAM (mode=0) or pointer-addressed FIFO
// (mode=1) over one shared storage array.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   chip_select  : block enable; 0 suppresses every request
//   mode         : 0 = RAM, 1 = FIFO
//   write_en     : write request
//   read_en      : read request
//   address      : RAM-mode word address (ignored in FIFO mode)
//   data_in      : write data
//   data_out     : registered read data, holds when no read is accepted
//   data_valid   : one-cycle pulse, data_out updated this cycle
//   full, empty  : FIFO status (0 / 1 in RAM mode)
//   count        : FIFO occupancy 0..DEPTH (0 in RAM mode)
//   overflow     : sticky, a FIFO write was rejected while full
//   underflow    : sticky, a FIFO read was rejected while empty
module param_mem_fifo
  import param_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  chip_select,
  input  logic                  mode,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt_q;

  logic mode_change;
  logic active;
  logic fifo_q;
  logic fifo_full;
  logic fifo_empty;
  logic ram_wr;
  logic ram_rd;
  logic wr_acc;
  logic rd_acc;
  logic mem_wr_en;
  logic mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;

  // A mode switch resets the pointers and swallows that cycle's requests,
  // so requests are qualified against the registered mode.
  assign mode_change = (mode != mode_q);
  assign active      = chip_select && !mode_change;
  assign fifo_q      = (mode_q == MODE_FIFO);
  assign fifo_full   = (cnt_q == DEPTH_CNT);
  assign fifo_empty  = (cnt_q == '0);

  assign ram_wr = active && !fifo_q && write_en;
  assign ram_rd = active && !fifo_q && read_en;
  assign rd_acc = active && fifo_q && read_en && !fifo_empty;
  // When full, a simultaneous accepted read frees the slot being written.
  assign wr_acc = active && fifo_q && write_en && (!fifo_full || rd_acc);

  assign mem_wr_en   = ram_wr || wr_acc;
  assign mem_rd_en   = ram_rd || rd_acc;
  assign mem_wr_addr = fifo_q ? wr_ptr : address;
  assign mem_rd_addr = fifo_q ? rd_ptr : address;

  mem_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem_core (
    .clock  (clock),
    .clear  (reset),
    .wr_en  (mem_wr_en),
    .wr_addr(mem_wr_addr),
    .wr_data(data_in),
    .rd_en  (mem_rd_en),
    .rd_addr(mem_rd_addr),
    .rd_data(data_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q     <= mode;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt_q      <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      mode_q     <= mode;
      data_valid <= mem_rd_en;
      if (mode_change) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt_q  <= '0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
          rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        end
        case ({wr_acc, rd_acc})
          2'b10:   cnt_q <= cnt_q + (ADDR_WIDTH+1)'(1);
          2'b01:   cnt_q <= cnt_q - (ADDR_WIDTH+1)'(1);
          default: cnt_q <= cnt_q;
        endcase
        if (active && fifo_q && write_en && !wr_acc) begin
          overflow <= 1'b1;
        end
        if (active && fifo_q && read_en && fifo_empty) begin
          underflow <= 1'b1;
        end
      end
    end
  end

  assign full  = fifo_q && fifo_full;
  assign empty = !fifo_q || fifo_empty;
  assign count = fifo_q ? cnt_q : '0;
endmodule
